// File: rtl/cw_deserializer.sv
// Bit-serial to 46-bit codeword framer with in-band SOF and a valid/ready output register.
// Optional build macro BURST_INJ_EN adds inj_* ports that XOR a burst into each loaded codeword.
module cw_deserializer #(
    parameter int N     = 46,
    parameter int B     = 6,
    parameter int OFS_W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ser_valid,
    input  logic         ser_bit,
    input  logic         ser_sof,
    output logic         cw_valid,
    input  logic         cw_ready,
    output logic [0:N-1] codeword,
    output logic         frame_err,
    output logic         ovf,
    output logic [15:0]  frame_cnt
`ifdef BURST_INJ_EN
    ,
    input  logic             inj_en,
    input  logic [OFS_W-1:0] inj_ofs,
    input  logic [0:B-1]     inj_pat
`endif
);

    localparam int CNT_W = $clog2(N);

    if ((2**OFS_W < N) || (B > N)) begin : g_bad_params
        $error("cw_deserializer: OFS_W too small for N, or B larger than N");
    end

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [0:N-1]       sreg_reg, sreg_next;
    logic [0:N-1]       codeword_reg, codeword_next;
    logic               cw_valid_reg, cw_valid_next;
    logic               frame_err_reg, frame_err_next;
    logic               ovf_reg, ovf_next;
    logic [15:0]        frame_cnt_reg, frame_cnt_next;

    logic               store;
    logic [CNT_W-1:0]   wr_idx;
    logic               complete;
    logic               out_free;
    logic [0:N-1]       inj_mask;
    logic [0:N-1]       load_val;

    // Framing FSM: a mid-frame SOF restarts the frame and wins over completion.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        store          = 1'b0;
        wr_idx         = cnt_reg;
        complete       = 1'b0;
        frame_err_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (ser_valid && ser_sof) begin
                    store      = 1'b1;
                    wr_idx     = '0;
                    cnt_next   = CNT_W'(1);
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (ser_valid) begin
                    store = 1'b1;
                    if (ser_sof) begin
                        wr_idx         = '0;
                        cnt_next       = CNT_W'(1);
                        frame_err_next = 1'b1;
                    end else if (cnt_reg == CNT_W'(N-1)) begin
                        complete   = 1'b1;
                        cnt_next   = '0;
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // sreg_next already contains the final bit, so it is the complete frame at completion.
    for (genvar gi = 0; gi < N; gi++) begin : g_sreg
        assign sreg_next[gi] = (store && (wr_idx == CNT_W'(gi))) ? ser_bit : sreg_reg[gi];
    end

`ifdef BURST_INJ_EN
    function automatic logic inj_bit(input logic en, input logic [OFS_W-1:0] ofs,
                                     input logic [0:B-1] pat, input int idx);
        inj_bit = 1'b0;
        for (int k = 0; k < B; k++) begin
            if (en && (int'(ofs) + k == idx)) begin
                inj_bit = pat[k];
            end
        end
    endfunction

    // Burst positions past the last bit never match an index, so they fall away.
    for (genvar gi = 0; gi < N; gi++) begin : g_inj
        assign inj_mask[gi] = inj_bit(inj_en, inj_ofs, inj_pat, gi);
    end
`else
    assign inj_mask = '0;
`endif

    assign load_val = sreg_next ^ inj_mask;
    assign out_free = !cw_valid_reg || cw_ready;

    always_comb begin
        codeword_next  = codeword_reg;
        cw_valid_next  = cw_valid_reg;
        frame_cnt_next = frame_cnt_reg;
        ovf_next       = 1'b0;
        if (complete && out_free) begin
            codeword_next  = load_val;
            cw_valid_next  = 1'b1;
            frame_cnt_next = frame_cnt_reg + 16'd1;
        end else begin
            if (complete) begin
                ovf_next = 1'b1;
            end
            if (cw_valid_reg && cw_ready) begin
                cw_valid_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            sreg_reg      <= '0;
            codeword_reg  <= '0;
            cw_valid_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            ovf_reg       <= 1'b0;
            frame_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            sreg_reg      <= sreg_next;
            codeword_reg  <= codeword_next;
            cw_valid_reg  <= cw_valid_next;
            frame_err_reg <= frame_err_next;
            ovf_reg       <= ovf_next;
            frame_cnt_reg <= frame_cnt_next;
        end
    end

    assign codeword  = codeword_reg;
    assign cw_valid  = cw_valid_reg;
    assign frame_err = frame_err_reg;
    assign ovf       = ovf_reg;
    assign frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_cw_deserializer.sv
// Self-checking bench for cw_deserializer: table-driven frames, scoreboard on delivered codewords,
// plus hand-written restart, overflow, injection and mid-frame reset sequences.
module tb_cw_deserializer;

    localparam int N = 46;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ser_valid = 1'b0;
    logic          ser_bit = 1'b0;
    logic          ser_sof = 1'b0;
    logic          cw_ready = 1'b0;
    logic          cw_valid;
    logic [0:N-1]  codeword;
    logic          frame_err;
    logic          ovf;
    logic [15:0]   frame_cnt;
`ifdef BURST_INJ_EN
    logic          inj_en = 1'b0;
    logic [5:0]    inj_ofs = '0;
    logic [0:5]    inj_pat = '0;
`endif

    cw_deserializer #(.N(N), .B(6), .OFS_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ser_valid (ser_valid),
        .ser_bit   (ser_bit),
        .ser_sof   (ser_sof),
        .cw_valid  (cw_valid),
        .cw_ready  (cw_ready),
        .codeword  (codeword),
        .frame_err (frame_err),
        .ovf       (ovf),
        .frame_cnt (frame_cnt)
`ifdef BURST_INJ_EN
        ,
        .inj_en    (inj_en),
        .inj_ofs   (inj_ofs),
        .inj_pat   (inj_pat)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int err_pulses = 0;
    int ovf_pulses = 0;
    int exp_cnt = 0;
    logic [0:N-1] sb_q[$];

    typedef struct {
        logic [0:N-1] pat;
        bit           gaps;
        logic [0:N-1] exp_cw;
    } vec_t;

    vec_t vecs[6];

    localparam logic [0:N-1] ONES = 46'h3FFF_FFFF_FFFF;
    localparam logic [0:N-1] ALT  = 46'h2AAA_AAAA_AAAA;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Transfers are judged at the falling edge, half a cycle before they happen.
    always @(negedge clk) begin
        logic [0:N-1] exp_cw;
        if (frame_err) err_pulses++;
        if (ovf) ovf_pulses++;
        if (rst_n && cw_valid && cw_ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_transfer: got %h required no transfer", codeword);
            end else begin
                exp_cw = sb_q.pop_front();
                $display("xfer codeword=%h expected=%h frame_cnt=%0d", codeword, exp_cw, frame_cnt);
                check("delivered_cw", 64'(codeword), 64'(exp_cw));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b, input logic sof);
        ser_valid = 1'b1;
        ser_bit   = b;
        ser_sof   = sof;
        @(posedge clk);
        #1;
        ser_valid = 1'b0;
        ser_sof   = 1'b0;
    endtask

    task automatic send_frame(input logic [0:N-1] pat, input bit gaps, input bit ready_on_last,
                              input bit chk_lat);
        for (int i = 0; i < N; i++) begin
            if (i == N-1 && ready_on_last) cw_ready = 1'b1;
            ser_valid = 1'b1;
            ser_bit   = pat[i];
            ser_sof   = (i == 0);
            if (i == N-1 && chk_lat) begin
                #2;
                check("valid_before_last_edge", 64'(cw_valid), 64'd0);
            end
            @(posedge clk);
            #1;
            ser_valid = 1'b0;
            ser_sof   = 1'b0;
            if (gaps && i != N-1) idle(1);
        end
        if (chk_lat) check("valid_after_last_edge", 64'(cw_valid), 64'd1);
    endtask

    initial begin
        int e0;
        int o0;

        vecs[0] = '{pat: ONES,              gaps: 1'b0, exp_cw: 46'h3FFF_FFFF_FFFF};
        vecs[1] = '{pat: ONES,              gaps: 1'b1, exp_cw: 46'h3FFF_FFFF_FFFF};
        vecs[2] = '{pat: ALT,               gaps: 1'b0, exp_cw: 46'h2AAA_AAAA_AAAA};
        vecs[3] = '{pat: 46'h0,             gaps: 1'b1, exp_cw: 46'h0};
        vecs[4] = '{pat: 46'h1234_5678_9ABC, gaps: 1'b0, exp_cw: 46'h1234_5678_9ABC};
        vecs[5] = '{pat: 46'h3C0F_00FF_A5A5, gaps: 1'b1, exp_cw: 46'h3C0F_00FF_A5A5};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_cw_valid", 64'(cw_valid), 64'd0);
        check("rst_codeword", 64'(codeword), 64'd0);
        check("rst_frame_err", 64'(frame_err), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        rst_n = 1'b1;
        cw_ready = 1'b1;
        idle(2);

        // Table-driven frames with the output always ready
        for (int v = 0; v < 6; v++) begin
            sb_q.push_back(vecs[v].exp_cw);
            exp_cnt++;
            send_frame(vecs[v].pat, vecs[v].gaps, 1'b0, 1'b1);
            check("frame_cnt", 64'(frame_cnt), 64'(exp_cnt));
            idle(2);
        end

        // SOF mid-frame: partial ALT frame restarted by an all-zero frame
        e0 = err_pulses;
        for (int i = 0; i < 20; i++) send_bit(ALT[i], (i == 0));
        sb_q.push_back(46'h0);
        exp_cnt++;
        send_frame(46'h0, 1'b0, 1'b0, 1'b1);
        idle(2);
        check("frame_err_pulses", 64'(err_pulses - e0), 64'd1);
        check("frame_cnt_after_err", 64'(frame_cnt), 64'(exp_cnt));

        // Output full: second frame dropped with ovf, first one held
        cw_ready = 1'b0;
        o0 = ovf_pulses;
        sb_q.push_back(ALT);
        exp_cnt++;
        send_frame(ALT, 1'b0, 1'b0, 1'b1);
        send_frame(46'h0, 1'b0, 1'b0, 1'b0);
        check("ovf_pulse_now", 64'(ovf), 64'd1);
        check("held_codeword", 64'(codeword), 64'(ALT));
        check("held_valid", 64'(cw_valid), 64'd1);
        check("frame_cnt_after_ovf", 64'(frame_cnt), 64'(exp_cnt));
        cw_ready = 1'b1;
        idle(2);
        check("ovf_pulses", 64'(ovf_pulses - o0), 64'd1);

        // Consume in the completing cycle: no ovf, B delivered right after A
        cw_ready = 1'b0;
        o0 = ovf_pulses;
        sb_q.push_back(ALT);
        exp_cnt++;
        send_frame(ALT, 1'b0, 1'b0, 1'b1);
        sb_q.push_back(46'h0);
        exp_cnt++;
        send_frame(46'h0, 1'b0, 1'b1, 1'b0);
        check("b_follows_a_valid", 64'(cw_valid), 64'd1);
        check("b_follows_a_cw", 64'(codeword), 64'd0);
        idle(2);
        check("no_ovf_on_consume", 64'(ovf_pulses - o0), 64'd0);
        check("frame_cnt_b2b", 64'(frame_cnt), 64'(exp_cnt));

`ifdef BURST_INJ_EN
        // Burst injection, including a burst that runs past the last bit
        inj_en  = 1'b1;
        inj_pat = 6'b111111;
        inj_ofs = 6'd40;
        sb_q.push_back(46'h3FFF_FFFF_FFC0);
        exp_cnt++;
        send_frame(ONES, 1'b0, 1'b0, 1'b1);
        idle(2);
        inj_ofs = 6'd43;
        sb_q.push_back(46'h3FFF_FFFF_FFF8);
        exp_cnt++;
        send_frame(ONES, 1'b0, 1'b0, 1'b1);
        idle(2);
        inj_en = 1'b0;
        check("frame_cnt_inj", 64'(frame_cnt), 64'(exp_cnt));
`endif

        // Reset mid-frame with a held codeword: everything is discarded
        cw_ready = 1'b0;
        send_frame(ONES, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) send_bit(1'b1, (i == 0));
        rst_n = 1'b0;
        #2;
        check("midrst_cw_valid", 64'(cw_valid), 64'd0);
        check("midrst_codeword", 64'(codeword), 64'd0);
        check("midrst_frame_cnt", 64'(frame_cnt), 64'd0);
        check("midrst_frame_err", 64'(frame_err), 64'd0);
        check("midrst_ovf", 64'(ovf), 64'd0);
        idle(2);
        rst_n = 1'b1;
        cw_ready = 1'b1;
        idle(1);
        sb_q.push_back(ONES);
        exp_cnt = 1;
        send_frame(ONES, 1'b0, 1'b0, 1'b1);
        check("frame_cnt_after_rst", 64'(frame_cnt), 64'(exp_cnt));
        idle(2);

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) idle(1);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
